// File: rtl/ucaspian_uart_pkg.sv
// Shared types and constants for the uCaspian UART receive/transmit paths.
package ucaspian_uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_rx_state_t;

  localparam int unsigned UART_DATA_BITS = 8;

endpackage

// File: rtl/ucaspian_byte_fifo.sv
// Show-ahead byte FIFO with an extra pointer MSB to tell full from empty.
module ucaspian_byte_fifo #(
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [7:0]             push_data,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [7:0]  mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign do_pop  = pop & ~empty;
  // A push into a full FIFO is only accepted when the head is leaving this cycle.
  assign do_push = push & (~full | do_pop);

  // Head byte is forced to zero while empty so the output is defined out of reset.
  assign dout = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

endmodule

// File: rtl/ucaspian_uart_rx.sv
// 8N1 UART receiver: synchroniser, bit-sampling FSM, byte FIFO and sticky error flags.
module ucaspian_uart_rx
  import ucaspian_uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        sys_clk,
  input  logic                        reset,
  input  logic                        uart_rx,
  output logic [7:0]                  rx_data,
  output logic                        rx_vld,
  input  logic                        rx_rdy,
  output logic                        frame_err,
  output logic                        overflow,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  input  logic                        clear_err
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(UART_DATA_BITS - 1);

  logic sync_meta;
  logic sync_line;
  logic line_prev;
  logic fall;

  uart_rx_state_t      state, state_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [IDX_W-1:0]    idx, idx_next;
  logic [7:0]          shreg, shreg_next;
  logic                push;
  logic                frame_set;
  logic                fifo_full;
  logic                fifo_empty;
  logic                pop;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      sync_meta <= 1'b1;
      sync_line <= 1'b1;
      line_prev <= 1'b1;
    end else begin
      sync_meta <= uart_rx;
      sync_line <= sync_meta;
      line_prev <= sync_line;
    end
  end

  assign fall = line_prev & ~sync_line;

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      idx   <= idx_next;
      shreg <= shreg_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    shreg_next = shreg;
    push       = 1'b0;
    frame_set  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          cnt_next   = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (cnt == '0) begin
          if (sync_line) begin
            state_next = IDLE;
          end else begin
            cnt_next   = FULL_LOAD;
            idx_next   = '0;
            state_next = DATA;
          end
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt == '0) begin
          shreg_next[idx] = sync_line;
          cnt_next        = FULL_LOAD;
          if (idx == LAST_IDX) state_next = STOP;
          else                 idx_next   = idx + IDX_W'(1);
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      STOP: begin
        // Leaving at mid-stop lets a back-to-back start edge be caught immediately.
        if (cnt == '0) begin
          if (sync_line) push      = 1'b1;
          else           frame_set = 1'b1;
          state_next = IDLE;
        end else begin
          cnt_next = cnt - CNT_W'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign rx_vld = ~fifo_empty;
  assign pop    = rx_vld & rx_rdy;

  ucaspian_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sys_clk),
    .rst       (reset),
    .push      (push),
    .push_data (shreg),
    .pop       (pop),
    .dout      (rx_data),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .level     (fifo_level)
  );

  // Set takes priority over clear so an error in the clearing cycle is not lost.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (frame_set)      frame_err <= 1'b1;
      else if (clear_err) frame_err <= 1'b0;
      if (push & fifo_full & ~pop) overflow <= 1'b1;
      else if (clear_err)          overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ucaspian_uart_rx.sv
// Directed bench for ucaspian_uart_rx with a scoreboard monitor on the byte stream.
module tb_ucaspian_uart_rx;

  localparam int unsigned CPB   = 16;
  localparam int unsigned DEPTH = 16;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic [7:0] rx_data;
  logic       rx_vld;
  logic       rx_rdy;
  logic       frame_err;
  logic       overflow;
  logic [4:0] fifo_level;
  logic       clear_err;

  int unsigned checks   = 0;
  int unsigned failures = 0;
  logic [7:0]  exp_q [$];

  always #5 sys_clk = ~sys_clk;

  ucaspian_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .uart_rx    (uart_rx),
    .rx_data    (rx_data),
    .rx_vld     (rx_vld),
    .rx_rdy     (rx_rdy),
    .frame_err  (frame_err),
    .overflow   (overflow),
    .fifo_level (fifo_level),
    .clear_err  (clear_err)
  );

  task automatic chk(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  // Scoreboard monitor: every accepted byte must match the oldest expected one.
  always @(negedge sys_clk) begin
    if (!reset && rx_vld && rx_rdy) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_byte: got %02h expected none", rx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (rx_data !== e) begin
          failures++;
          $display("FAIL rx_data: got %02h expected %02h", rx_data, e);
        end
      end
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit expect_it);
    if (expect_it) exp_q.push_back(b);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge sys_clk);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge sys_clk);
    uart_rx = 1'b1;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_rx_vld"},     int'(rx_vld),     0);
    chk({tag, "_rx_data"},    int'(rx_data),    0);
    chk({tag, "_frame_err"},  int'(frame_err),  0);
    chk({tag, "_overflow"},   int'(overflow),   0);
    chk({tag, "_fifo_level"}, int'(fifo_level), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    reset     = 1'b1;
    uart_rx   = 1'b1;
    rx_rdy    = 1'b1;
    clear_err = 1'b0;
    repeat (3) @(negedge sys_clk);
    check_idle_outputs("reset");
    reset = 1'b0;
    repeat (5) @(negedge sys_clk);

    // 1: single frame, latency from start edge to rx_vld
    n = 0;
    fork
      send_frame(8'hA5, 1'b1, 1'b1);
      begin
        while (!rx_vld && n < 400) begin
          @(negedge sys_clk);
          n++;
        end
      end
    join
    chk("latency_cycles", n, 155);
    chk("t1_frame_err", int'(frame_err), 0);
    repeat (4) @(negedge sys_clk);

    // 2: short glitch must not start a frame
    uart_rx = 1'b0;
    repeat (4) @(negedge sys_clk);
    uart_rx = 1'b1;
    repeat (40) @(negedge sys_clk);
    chk("glitch_rx_vld", int'(rx_vld), 0);
    chk("glitch_frame_err", int'(frame_err), 0);
    send_frame(8'h5A, 1'b1, 1'b1);
    repeat (4) @(negedge sys_clk);

    // 3: bad stop bit
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (2) @(negedge sys_clk);
    chk("badstop_frame_err", int'(frame_err), 1);
    chk("badstop_level", int'(fifo_level), 0);
    chk("badstop_rx_vld", int'(rx_vld), 0);
    clear_err = 1'b1;
    @(negedge sys_clk);
    clear_err = 1'b0;
    @(negedge sys_clk);
    chk("clear_frame_err", int'(frame_err), 0);

    // 4: fill past capacity with consumer stalled
    rx_rdy = 1'b0;
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1, i < 16);
    repeat (2) @(negedge sys_clk);
    chk("full_level", int'(fifo_level), 16);
    chk("full_overflow", int'(overflow), 1);
    chk("full_head", int'(rx_data), 8'h00);
    chk("full_frame_err", int'(frame_err), 0);
    rx_rdy = 1'b1;
    repeat (24) @(negedge sys_clk);
    chk("drain_level", int'(fifo_level), 0);
    chk("drain_queue", exp_q.size(), 0);
    clear_err = 1'b1;
    @(negedge sys_clk);
    clear_err = 1'b0;
    @(negedge sys_clk);
    chk("clear_overflow", int'(overflow), 0);

    // 5: back-to-back frames
    send_frame(8'h00, 1'b1, 1'b1);
    send_frame(8'hFF, 1'b1, 1'b1);
    repeat (4) @(negedge sys_clk);
    chk("b2b_frame_err", int'(frame_err), 0);
    chk("b2b_queue", exp_q.size(), 0);

    // 6: reset mid-DATA clears stored bytes and flags
    rx_rdy = 1'b0;
    send_frame(8'h42, 1'b1, 1'b0);
    send_frame(8'h99, 1'b0, 1'b0);
    chk("pre_reset_level", int'(fifo_level), 1);
    chk("pre_reset_frame_err", int'(frame_err), 1);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge sys_clk);
    for (int i = 0; i < 3; i++) begin
      uart_rx = i[0] ? 1'b0 : 1'b1;
      repeat (CPB) @(negedge sys_clk);
    end
    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (2) @(negedge sys_clk);
    check_idle_outputs("midreset");
    reset  = 1'b0;
    rx_rdy = 1'b1;
    repeat (20) @(negedge sys_clk);
    chk("post_reset_rx_vld", int'(rx_vld), 0);
    send_frame(8'h81, 1'b1, 1'b1);
    repeat (4) @(negedge sys_clk);
    chk("final_queue", exp_q.size(), 0);
    chk("final_frame_err", int'(frame_err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
